datamem_arbiter: RTL and testbench

Two-port arbiter sharing the single-port data memory between requester A (CPU load/store unit) and requester B (program loader / debug port). It sits between both requesters and the data memory, selects one access per cycle with round-robin fairness plus a bounded lock for atomic sequences, drives the memory's write-enable/address/write-data inputs, and returns registered read data to the granted requester one cycle later.

---
 rtl/datamem_arbiter.sv | 144 ++++++++++++++
 tb/tb_datamem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datamem_arbiter.sv
// datamem_arbiter
//   Shares one single-port data memory between requester A (CPU LSU) and
//   requester B (loader / debug). One access is granted per cycle using
//   round-robin on ties, with an optional bounded lock that lets a requester
//   keep the memory for up to MAX_LOCK consecutive grants. Read data is
//   registered and returned to the granted port one cycle after the grant.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   a_* / b_*  (inputs)      req, we, lock, addr, wd per requester
//   a_gnt / b_gnt            combinational grant, at most one per cycle
//   a_rvalid / b_rvalid      single-cycle read response pulse
//   a_rdata / b_rdata        read data, held until the next read response
//   mem_wr_en/addr/wd        memory drive, zero when nothing is granted
//   mem_rd                   combinational read data from memory
module datamem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_LOCK      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_req,
    input  logic                     a_we,
    input  logic                     a_lock,
    input  logic [ADDRESS_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0]    a_wd,
    input  logic                     b_req,
    input  logic                     b_we,
    input  logic                     b_lock,
    input  logic [ADDRESS_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0]    b_wd,
    output logic                     a_gnt,
    output logic                     b_gnt,
    output logic                     a_rvalid,
    output logic                     b_rvalid,
    output logic [DATA_WIDTH-1:0]    a_rdata,
    output logic [DATA_WIDTH-1:0]    b_rdata,
    output logic                     mem_wr_en,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {FREE, LOCK_A, LOCK_B} state_t;

    typedef struct packed {
        logic                     we;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    wd;
    } mem_req_t;

    state_t           state, state_nxt;
    logic             last_b, last_b_nxt;      // 1: most recent grant went to B
    logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
    logic             lock_more;               // lock_cnt+1 < MAX_LOCK
    mem_req_t         sel;

    assign lock_more = (int'(lock_cnt) + 1) < MAX_LOCK;

    // Grant selection. A lock holder that stops requesting simply loses
    // priority; the other port may take the memory in that same cycle.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            case (state)
                LOCK_A: begin
                    if (a_req) a_gnt = 1'b1;
                    else       b_gnt = b_req;
                end
                LOCK_B: begin
                    if (b_req) b_gnt = 1'b1;
                    else       a_gnt = a_req;
                end
                default: begin
                    if (a_req && b_req) begin
                        a_gnt = last_b;
                        b_gnt = !last_b;
                    end else begin
                        a_gnt = a_req;
                        b_gnt = b_req;
                    end
                end
            endcase
        end
    end

    // Memory drive mux; all-zero when idle.
    always_comb begin
        sel = '0;
        if (a_gnt)      sel = '{we: a_we, addr: a_addr, wd: a_wd};
        else if (b_gnt) sel = '{we: b_we, addr: b_addr, wd: b_wd};
    end

    assign mem_wr_en = sel.we;
    assign mem_addr  = sel.addr;
    assign mem_wd    = sel.wd;

    // Lock bookkeeping. Any cycle that does not extend a lock falls back to
    // FREE with a cleared counter. Reaching MAX_LOCK releases the lock while
    // last_grant still points at the holder, so the other side wins the tie.
    always_comb begin
        state_nxt    = FREE;
        lock_cnt_nxt = '0;
        last_b_nxt   = last_b;
        if (a_gnt) begin
            last_b_nxt = 1'b0;
            if (a_lock && (state != LOCK_A || lock_more)) begin
                state_nxt    = LOCK_A;
                lock_cnt_nxt = (state == LOCK_A) ? lock_cnt + 1'b1 : CNT_W'(1);
            end
        end else if (b_gnt) begin
            last_b_nxt = 1'b1;
            if (b_lock && (state != LOCK_B || lock_more)) begin
                state_nxt    = LOCK_B;
                lock_cnt_nxt = (state == LOCK_B) ? lock_cnt + 1'b1 : CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            last_b   <= 1'b1;
            lock_cnt <= '0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            state    <= state_nxt;
            last_b   <= last_b_nxt;
            lock_cnt <= lock_cnt_nxt;
            a_rvalid <= a_gnt && !a_we;
            b_rvalid <= b_gnt && !b_we;
            if (a_gnt && !a_we) a_rdata <= mem_rd;
            if (b_gnt && !b_we) b_rdata <= mem_rd;
        end
    end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Self-checking bench for datamem_arbiter: directed sequences, a table of
// grant vectors, then randomized traffic against a run-length reference model.
module tb_datamem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int ML = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wd, b_wd;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd, mem_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    datamem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wd(a_wd),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wd(b_wd),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Simple 256-word memory; contents start as i*0x01010101.
    logic [DW-1:0] mem [0:255];
    logic          mem_init = 1'b1;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= i * 32'h0101_0101;
        end else if (mem_wr_en) begin
            mem[mem_addr[7:0]] <= mem_wd;
        end
    end
    assign mem_rd = mem[mem_addr[7:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step(input logic ar, br, awe, bwe, al, bl,
                        input logic [31:0] aa, ba, awd, bwd);
        @(posedge clk); #1;
        rst = 1'b0;
        a_req = ar; b_req = br; a_we = awe; b_we = bwe; a_lock = al; b_lock = bl;
        a_addr = aa; b_addr = ba; a_wd = awd; b_wd = bwd;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        a_req = 0; b_req = 0; a_we = 0; b_we = 0; a_lock = 0; b_lock = 0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic ar, br, awe, bwe, al, bl;
        logic ega, egb;
    } vec_t;

    function automatic vec_t mk(input logic ar, br, awe, bwe, al, bl, ega, egb);
        vec_t v;
        v.ar = ar; v.br = br; v.awe = awe; v.bwe = bwe; v.al = al; v.bl = bl;
        v.ega = ega; v.egb = egb;
        return v;
    endfunction

    vec_t tbl [16];

    // Reference model state for the random phase
    int            last, holder, run, prev, g;
    logic          erv_a, erv_b;
    logic [31:0]   erd_a, erd_b;
    logic [31:0]   model_mem [8];

    initial begin
        rst = 1'b1;
        a_req = 1; b_req = 1; a_we = 0; b_we = 0; a_lock = 0; b_lock = 0;
        a_addr = 0; b_addr = 0; a_wd = 0; b_wd = 0;

        // ---------------- reset behaviour ----------------
        @(posedge clk); #1;
        mem_init = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rst_a_gnt", a_gnt, 0);
            chk("rst_b_gnt", b_gnt, 0);
            chk("rst_wr_en", mem_wr_en, 0);
            chk("rst_a_rvalid", a_rvalid, 0);
            chk("rst_b_rvalid", b_rvalid, 0);
            chk("rst_a_rdata", a_rdata, 0);
            chk("rst_b_rdata", b_rdata, 0);
            @(posedge clk); #1;
        end
        step(1, 1, 0, 0, 0, 0, 1, 2, 0, 0);
        chk("post_rst_a_gnt", a_gnt, 1);
        chk("post_rst_b_gnt", b_gnt, 0);

        // ---------------- single port write then read ----------------
        do_reset();
        step(1, 0, 1, 0, 0, 0, 32'h10, 0, 32'hDEAD_BEEF, 0);
        chk("sp_wr_gnt", a_gnt, 1);
        chk("sp_wr_en", mem_wr_en, 1);
        chk("sp_wr_addr", mem_addr, 32'h10);
        chk("sp_wr_wd", mem_wd, 32'hDEAD_BEEF);
        step(1, 0, 0, 0, 0, 0, 32'h10, 0, 0, 0);
        chk("sp_rd_gnt", a_gnt, 1);
        chk("sp_rd_wr_en", mem_wr_en, 0);
        chk("sp_rd_no_rvalid", a_rvalid, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sp_rvalid", a_rvalid, 1);
        chk("sp_rdata", a_rdata, 32'hDEAD_BEEF);
        chk("sp_b_rvalid", b_rvalid, 0);
        chk("sp_idle_addr", mem_addr, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sp_rvalid_pulse", a_rvalid, 0);
        chk("sp_rdata_hold", a_rdata, 32'hDEAD_BEEF);

        // ---------------- round robin ----------------
        do_reset();
        for (int k = 0; k < 7; k++) begin
            if (k < 6) step(1, 1, 0, 0, 0, 0, 1, 2, 0, 0);
            else       step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (k < 6) begin
                chk("rr_a_gnt", a_gnt, (k % 2) == 0);
                chk("rr_b_gnt", b_gnt, (k % 2) == 1);
            end
            if (k >= 1) begin
                chk("rr_a_rvalid", a_rvalid, ((k - 1) % 2) == 0);
                chk("rr_b_rvalid", b_rvalid, ((k - 1) % 2) == 1);
            end
        end
        chk("rr_a_rdata", a_rdata, 32'h0101_0101);
        chk("rr_b_rdata", b_rdata, 32'h0202_0202);

        // ---------------- lock bound ----------------
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(1, 1, 0, 0, 1, 0, 3, 4, 0, 0);
            chk("lb_a_gnt", a_gnt, k != 8);
            chk("lb_b_gnt", b_gnt, k == 8);
        end

        // ---------------- lock release ----------------
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0, 0, 1, 0, 3, 4, 0, 0);
            chk("lr_a_gnt", a_gnt, 1);
        end
        step(0, 1, 0, 0, 0, 0, 3, 4, 0, 0);
        chk("lr_b_gnt", b_gnt, 1);
        chk("lr_a_gnt_drop", a_gnt, 0);
        step(1, 1, 0, 0, 0, 0, 3, 4, 0, 0);
        chk("lr_free_a_gnt", a_gnt, 1);

        // ---------------- reset mid-lock ----------------
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 0, 0, 1, 0, 5, 6, 0, 0);
            chk("rml_a_gnt", a_gnt, 1);
        end
        @(posedge clk); #1;
        rst = 1'b1; b_req = 1'b1;
        @(negedge clk);
        chk("rml_rst_a_gnt", a_gnt, 0);
        chk("rml_rst_b_gnt", b_gnt, 0);
        chk("rml_rst_wr_en", mem_wr_en, 0);
        for (int k = 0; k < 10; k++) begin
            step(1, 1, 0, 0, 1, 0, 5, 6, 0, 0);
            if (k == 0) chk("rml_rvalid_cleared", a_rvalid, 0);
            chk("rml_a_gnt2", a_gnt, k != 8);
            chk("rml_b_gnt2", b_gnt, k == 8);
        end

        // ---------------- table-driven grant vectors ----------------
        //            ar br awe bwe al bl  ga gb
        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 1, 0);
        tbl[1]  = mk(1, 1, 0, 1, 0, 0, 0, 1);
        tbl[2]  = mk(1, 0, 1, 0, 0, 0, 1, 0);
        tbl[3]  = mk(1, 1, 0, 0, 0, 0, 0, 1);
        tbl[4]  = mk(1, 1, 0, 0, 1, 0, 1, 0);
        tbl[5]  = mk(1, 1, 1, 0, 1, 0, 1, 0);
        tbl[6]  = mk(0, 1, 0, 0, 0, 0, 0, 1);
        tbl[7]  = mk(1, 1, 0, 0, 0, 0, 1, 0);
        tbl[8]  = mk(0, 0, 1, 1, 0, 0, 0, 0);
        tbl[9]  = mk(1, 1, 0, 0, 0, 1, 0, 1);
        tbl[10] = mk(1, 1, 0, 1, 0, 0, 0, 1);
        tbl[11] = mk(1, 1, 0, 0, 0, 0, 1, 0);
        tbl[12] = mk(1, 1, 0, 0, 1, 1, 0, 1);
        tbl[13] = mk(1, 1, 0, 0, 1, 1, 0, 1);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[15] = mk(1, 1, 0, 0, 0, 0, 1, 0);
        do_reset();
        for (int i = 0; i < 16; i++) begin
            logic [31:0] aa, ba, exp_addr;
            logic        exp_we;
            aa = 32'h20 + i;
            ba = 32'h40 + i;
            step(tbl[i].ar, tbl[i].br, tbl[i].awe, tbl[i].bwe, tbl[i].al, tbl[i].bl,
                 aa, ba, 32'hA000_0000 + i, 32'hB000_0000 + i);
            exp_we   = (tbl[i].ega & tbl[i].awe) | (tbl[i].egb & tbl[i].bwe);
            exp_addr = tbl[i].ega ? aa : (tbl[i].egb ? ba : 32'h0);
            chk($sformatf("tbl%0d_a_gnt", i), a_gnt, tbl[i].ega);
            chk($sformatf("tbl%0d_b_gnt", i), b_gnt, tbl[i].egb);
            chk($sformatf("tbl%0d_wr_en", i), mem_wr_en, exp_we);
            chk($sformatf("tbl%0d_addr", i), mem_addr, exp_addr);
        end

        // ---------------- randomized traffic vs. model ----------------
        // Model: the holder keeps priority while requesting; a lock run ends
        // when the holder drops lock, or after ML consecutive grants.
        do_reset();
        for (int i = 0; i < 8; i++) model_mem[i] = (32'h80 + i) * 32'h0101_0101;
        last = 1; holder = -1; run = 0;
        erv_a = 0; erv_b = 0; erd_a = 0; erd_b = 0;
        for (int c = 0; c < 3000; c++) begin
            logic r;
            @(posedge clk); #1;
            r       = ($urandom_range(0, 49) == 0);
            rst     = r;
            a_req   = ($urandom_range(0, 3) != 0);
            b_req   = ($urandom_range(0, 3) != 0);
            a_we    = $urandom_range(0, 1);
            b_we    = $urandom_range(0, 1);
            a_lock  = $urandom_range(0, 1);
            b_lock  = $urandom_range(0, 1);
            a_addr  = 32'h80 + $urandom_range(0, 7);
            b_addr  = 32'h80 + $urandom_range(0, 7);
            a_wd    = $urandom;
            b_wd    = $urandom;

            if (r)                                         g = -1;
            else if (holder == 0 && a_req)                 g = 0;
            else if (holder == 1 && b_req)                 g = 1;
            else if (a_req && b_req)                       g = 1 - last;
            else if (a_req)                                g = 0;
            else if (b_req)                                g = 1;
            else                                           g = -1;

            @(negedge clk);
            chk("rnd_a_gnt", a_gnt, g == 0);
            chk("rnd_b_gnt", b_gnt, g == 1);
            chk("rnd_wr_en", mem_wr_en, (g == 0) ? a_we : (g == 1) ? b_we : 1'b0);
            chk("rnd_addr", mem_addr, (g == 0) ? a_addr : (g == 1) ? b_addr : 32'h0);
            chk("rnd_wd", mem_wd, (g == 0) ? a_wd : (g == 1) ? b_wd : 32'h0);
            chk("rnd_a_rvalid", a_rvalid, erv_a);
            chk("rnd_b_rvalid", b_rvalid, erv_b);
            chk("rnd_a_rdata", a_rdata, erd_a);
            chk("rnd_b_rdata", b_rdata, erd_b);

            if (r) begin
                holder = -1; run = 0; last = 1;
                erv_a = 0; erv_b = 0; erd_a = 0; erd_b = 0;
            end else begin
                erv_a = (g == 0) && !a_we;
                erv_b = (g == 1) && !b_we;
                if (erv_a) erd_a = model_mem[a_addr - 32'h80];
                if (erv_b) erd_b = model_mem[b_addr - 32'h80];
                if (g >= 0) begin
                    prev = holder;
                    run  = (g == prev) ? run + 1 : 1;
                    last = g;
                    if (((g == 0) ? a_lock : b_lock) && (g != prev || run < ML)) holder = g;
                    else                                                         holder = -1;
                    if (g == 0 && a_we) model_mem[a_addr - 32'h80] = a_wd;
                    if (g == 1 && b_we) model_mem[b_addr - 32'h80] = b_wd;
                end else begin
                    holder = -1;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
